// File: rtl/lsu_mem_scheduler_if.sv
// Data-memory request channel between the LSU scheduler (master) and memory (slave).
// A request is offered with mem_req_valid and transfers on a cycle where mem_req_valid and mem_req_ready are both high.
interface lsu_mem_scheduler_if #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 32
);
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_req_write;
  logic [XLEN-1:0]          mem_req_address;
  logic [XLEN-1:0]          mem_req_data;
  logic [ROB_TAG_WIDTH-1:0] mem_req_rob_tag;

  modport master (
    output mem_req_valid,
    input  mem_req_ready,
    output mem_req_write,
    output mem_req_address,
    output mem_req_data,
    output mem_req_rob_tag
  );

  modport slave (
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_req_write,
    input  mem_req_address,
    input  mem_req_data,
    input  mem_req_rob_tag
  );
endinterface

// File: rtl/lsu_mem_scheduler.sv
// Arbitrates the single data-memory port between the oldest ready load and the committed STQ head,
// holding one registered request until accepted. A starvation counter bounds how long a ready store waits.
module lsu_mem_scheduler #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 32,
  parameter int LDQ_SIZE      = 32,
  parameter int STQ_SIZE      = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [LDQ_SIZE-1:0]                ldq_rotated_valid,
  input  logic [LDQ_SIZE-1:0]                ldq_rotated_address_valid,
  input  logic [LDQ_SIZE-1:0]                ldq_rotated_sleeping,
  input  logic [LDQ_SIZE-1:0]                ldq_rotated_executed,
  input  logic [$clog2(LDQ_SIZE)-1:0]        ldq_head,
  input  logic [LDQ_SIZE*XLEN-1:0]           ldq_address,
  input  logic [LDQ_SIZE*ROB_TAG_WIDTH-1:0]  ldq_rob_tag,
  input  logic                               stq_head_ready,
  input  logic [$clog2(STQ_SIZE)-1:0]        stq_head_index,
  input  logic [XLEN-1:0]                    stq_head_address,
  input  logic [XLEN-1:0]                    stq_head_data,
  lsu_mem_scheduler_if.master                mem,
  output logic                               load_fired,
  output logic [$clog2(LDQ_SIZE)-1:0]        load_fired_index,
  output logic                               store_fired,
  output logic [$clog2(STQ_SIZE)-1:0]        store_fired_index,
  output logic                               busy,
  output logic                               dbg_state,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]  dbg_starve_cnt
);

  localparam int LIDX_W = $clog2(LDQ_SIZE);
  localparam int SIDX_W = $clog2(STQ_SIZE);
  localparam int SCW    = $clog2(STARVE_LIMIT + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [SCW-1:0]           starve_q, starve_d;
  logic                     write_q, write_d;
  logic [XLEN-1:0]          addr_q, addr_d;
  logic [XLEN-1:0]          data_q, data_d;
  logic [ROB_TAG_WIDTH-1:0] tag_q, tag_d;
  logic [LIDX_W-1:0]        lidx_q, lidx_d;
  logic [SIDX_W-1:0]        sidx_q, sidx_d;

  logic [LDQ_SIZE-1:0]      ld_rdy;
  logic                     ld_found;
  logic [LIDX_W-1:0]        ld_pos;
  logic [LIDX_W-1:0]        ld_index;
  logic [XLEN-1:0]          ld_addr_sel;
  logic [ROB_TAG_WIDTH-1:0] ld_tag_sel;
  logic                     starved;
  logic                     store_win;
  logic                     accept;
  logic                     drop_req;

  assign ld_rdy = ldq_rotated_valid & ldq_rotated_address_valid &
                  ~ldq_rotated_sleeping & ~ldq_rotated_executed;

  // Rotated bit 0 is the LDQ head, so the lowest ready bit is the oldest ready load.
  always_comb begin
    ld_found = 1'b0;
    ld_pos   = '0;
    for (int i = LDQ_SIZE - 1; i >= 0; i--) begin
      if (ld_rdy[i]) begin
        ld_found = 1'b1;
        ld_pos   = LIDX_W'(i);
      end
    end
  end

  assign ld_index = ld_pos + ldq_head;

  always_comb begin
    ld_addr_sel = '0;
    ld_tag_sel  = '0;
    for (int i = 0; i < LDQ_SIZE; i++) begin
      if (ld_index == LIDX_W'(i)) begin
        ld_addr_sel = ldq_address[i*XLEN +: XLEN];
        ld_tag_sel  = ldq_rob_tag[i*ROB_TAG_WIDTH +: ROB_TAG_WIDTH];
      end
    end
  end

  assign starved   = (starve_q == SCW'(STARVE_LIMIT));
  assign store_win = stq_head_ready && (!ld_found || starved);
  assign accept    = (state_q == ST_REQ) && mem.mem_req_ready;
  // A latched store is committed and survives flush; a latched load is squashed.
  assign drop_req  = (state_q == ST_REQ) && flush && !write_q;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    write_d  = write_q;
    addr_d   = addr_q;
    data_d   = data_q;
    tag_d    = tag_q;
    lidx_d   = lidx_q;
    sidx_d   = sidx_q;
    case (state_q)
      ST_IDLE: begin
        if (!flush && (store_win || ld_found)) begin
          state_d = ST_REQ;
          if (store_win) begin
            write_d  = 1'b1;
            addr_d   = stq_head_address;
            data_d   = stq_head_data;
            tag_d    = '0;
            lidx_d   = '0;
            sidx_d   = stq_head_index;
            starve_d = '0;
          end else begin
            write_d = 1'b0;
            addr_d  = ld_addr_sel;
            data_d  = '0;
            tag_d   = ld_tag_sel;
            lidx_d  = ld_index;
            sidx_d  = '0;
            if (stq_head_ready && !starved) begin
              starve_d = starve_q + 1'b1;
            end
          end
        end
      end
      default: begin
        if (drop_req || accept) begin
          state_d = ST_IDLE;
          write_d = 1'b0;
          addr_d  = '0;
          data_d  = '0;
          tag_d   = '0;
          lidx_d  = '0;
          sidx_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      tag_q    <= '0;
      lidx_q   <= '0;
      sidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
      lidx_q   <= lidx_d;
      sidx_q   <= sidx_d;
    end
  end

  assign mem.mem_req_valid   = (state_q == ST_REQ);
  assign mem.mem_req_write   = write_q;
  assign mem.mem_req_address = addr_q;
  assign mem.mem_req_data    = data_q;
  assign mem.mem_req_rob_tag = tag_q;

  assign load_fired        = accept && !write_q && !flush;
  assign load_fired_index  = load_fired ? lidx_q : '0;
  assign store_fired       = accept && write_q;
  assign store_fired_index = store_fired ? sidx_q : '0;
  assign busy              = (state_q == ST_REQ);
  assign dbg_state         = state_q;
  assign dbg_starve_cnt    = starve_q;

endmodule

// File: doc/lsu_mem_scheduler.md
Name: lsu_mem_scheduler

Overview:
- Sequences the single data-memory request port between the load queue and the store queue head.
- Each idle cycle it picks the oldest ready load, or the committed store at the STQ head, and registers a request.
- It holds the request until memory accepts it, then pulses the fire handshake back to the LDQ or STQ.
- Uses age priority for loads, with a starvation counter that guarantees committed stores make progress.

Parameters:
- XLEN, 32, data/address width
- ROB_TAG_WIDTH, 32, ROB tag width
- LDQ_SIZE, 32, load queue entries (power of two)
- STQ_SIZE, 32, store queue entries (power of two)
- STARVE_LIMIT, 4, consecutive load wins tolerated while a store is ready; minimum 1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  squash uncommitted work; a latched, unaccepted load request is dropped
- ldq_rotated_valid  in  LDQ_SIZE  valid bits, head at bit 0
- ldq_rotated_address_valid  in  LDQ_SIZE  address known, head at bit 0
- ldq_rotated_sleeping  in  LDQ_SIZE  sleeping, head at bit 0
- ldq_rotated_executed  in  LDQ_SIZE  executed, head at bit 0
- ldq_head  in  $clog2(LDQ_SIZE)  LDQ head pointer
- ldq_address  in  LDQ_SIZE*XLEN  per-entry address, unrotated
- ldq_rob_tag  in  LDQ_SIZE*ROB_TAG_WIDTH  per-entry ROB tag, unrotated
- stq_head_ready  in  1  STQ head is committed, address+data valid, not yet fired
- stq_head_index  in  $clog2(STQ_SIZE)  STQ head index
- stq_head_address  in  XLEN  store address
- stq_head_data  in  XLEN  store data
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts the request this cycle
- mem_req_write  out  1  1 = store, 0 = load
- mem_req_address  out  XLEN  request address
- mem_req_data  out  XLEN  store data; 0 for loads
- mem_req_rob_tag  out  ROB_TAG_WIDTH  load ROB tag; 0 for stores
- load_fired  out  1  load accepted this cycle
- load_fired_index  out  $clog2(LDQ_SIZE)  LDQ index of the accepted load
- store_fired  out  1  store accepted this cycle
- store_fired_index  out  $clog2(STQ_SIZE)  STQ index of the accepted store
- busy  out  1  state == REQ

Behaviour:
- Reset (synchronous, active-high): state IDLE, starve_cnt 0, every request register 0. All outputs 0, including mem_req_*, load_fired*, store_fired* and busy.
- Load candidate:
  - rdy = valid & address_valid & ~sleeping & ~executed, computed on the rotated vectors.
  - pos = lowest set bit of rdy.
  - index = (pos + ldq_head) mod LDQ_SIZE. The adder wraps naturally at $clog2(LDQ_SIZE) bits.
- States: IDLE, REQ.
- IDLE, no candidate and !stq_head_ready: stay in IDLE.
- IDLE, arbitration when a candidate exists:
  - Store wins if stq_head_ready and (no load candidate, or starve_cnt == STARVE_LIMIT).
  - Otherwise the load wins.
- IDLE, latching the winner (registers write, address, data, tag, index, kind), then go to REQ:
  - Load winner: data = 0, tag = ldq_rob_tag[index]; also increment starve_cnt if stq_head_ready (saturating at STARVE_LIMIT).
  - Store winner: tag = 0, starve_cnt <= 0.
- IDLE, flush: no selection that cycle.
- Latency: a candidate visible in cycle N gives mem_req_valid=1 in cycle N+1.
- REQ:
  - mem_req_valid = 1. All mem_req_* outputs stay stable until accepted.
  - On mem_req_valid & mem_req_ready: pulse load_fired or store_fired with the latched index, combinationally in the same cycle. Next state is IDLE.
  - Peak rate is one request per 2 cycles. The fired entry's executed/fired bit updates at the same edge, so it is not reselected.
- Flush in REQ:
  - Latched load: dropped whether or not mem_req_ready is high. No load_fired; next state IDLE; mem_req_valid 0 next cycle.
  - Latched store: unaffected by flush (it is committed).
- While in REQ, input changes (a new older load, a sleep, etc.) do not alter the latched request.
- load_fired and store_fired are never both 1. Each is at most one cycle per accepted request.
- Reset mid-REQ: the request is abandoned and outputs return to 0 the next cycle.

Test Plan:
1. Wrap-around selection. ldq_head=30, LDQ_SIZE=32, rotated rdy bits 3 and 5 set, mem_req_ready=1 constant. Required: cycle N+1 mem_req_valid=1, write=0, address=ldq_address[1], tag=ldq_rob_tag[1]; load_fired=1 with load_fired_index=1.
2. Backpressure. Store ready with index 7, address 0x100, data 0xDEADBEEF, no load candidate, mem_req_ready=0 for 3 cycles then 1. Required: request held stable for 4 cycles; store_fired=1 with index 7 only in cycle 4; busy then falls.
3. Starvation. stq_head_ready=1 constantly, a new load candidate every IDLE cycle, STARVE_LIMIT=4, ready=1. Required: 4 load requests, then 1 store request; starve_cnt returns to 0.
4. Flush load vs store. Flush asserted in REQ with a latched load and ready=1: no load_fired, IDLE next cycle. Repeat with a latched store: store_fired=1.
5. Ineligible entries. Entries that are sleeping, executed, or address-invalid are never selected; all-zero rdy with !stq_head_ready keeps mem_req_valid=0.
6. Reset mid-REQ. Assert reset while mem_req_valid=1: next cycle all outputs are 0 and state is IDLE.
